// File: rtl/alu_pkg.sv
// Shared ALU definitions: select-code width, flag bit positions and the
// default mask of select codes that are arithmetic operations.
package alu_pkg;

   localparam int unsigned ALU_SEL_W = 4;
   localparam int unsigned NUM_SEL   = 2 ** ALU_SEL_W;
   localparam int unsigned NUM_FLAGS = 4;

   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   localparam logic [NUM_SEL-1:0] ARITH_MASK_DEFAULT = 16'h000F;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational {Z,N,C,V} generation for one result. Carry and overflow
// only pass through for select codes marked arithmetic in ARITH_MASK.
module alu_flag_gen
   import alu_pkg::*;
#(
   parameter int unsigned        WIDTH      = 8,
   parameter logic [NUM_SEL-1:0] ARITH_MASK = ARITH_MASK_DEFAULT
) (
   input  logic [WIDTH-1:0]     res,
   input  logic [ALU_SEL_W-1:0] sel,
   input  logic                 cout,
   input  logic                 ovf,
   output logic [NUM_FLAGS-1:0] flags
);

   logic arith;

   // Derive the four status flags from the result and adder outputs
   always_comb begin
      flags         = '0;
      arith         = ARITH_MASK[sel];
      flags[FLAG_Z] = (res == '0);
      flags[FLAG_N] = res[WIDTH-1];
      flags[FLAG_C] = arith & cout;
      flags[FLAG_V] = arith & ovf;
   end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: two-entry skid buffer (output register + skid register)
// between the result mux and the downstream consumer. Flags are computed on
// accept and travel with their result; sticky_v records any overflow seen.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int unsigned        WIDTH      = 8,
   parameter logic [NUM_SEL-1:0] ARITH_MASK = ARITH_MASK_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_res,
   input  logic [ALU_SEL_W-1:0] in_sel,
   input  logic                 in_cout,
   input  logic                 in_ovf,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_res,
   output logic [ALU_SEL_W-1:0] out_sel,
   output logic [NUM_FLAGS-1:0] out_flags,
   output logic                 sticky_v
);

   logic [NUM_FLAGS-1:0] in_flags;

   logic                 out_valid_q;
   logic [WIDTH-1:0]     out_res_q;
   logic [ALU_SEL_W-1:0] out_sel_q;
   logic [NUM_FLAGS-1:0] out_flags_q;

   logic                 skid_valid_q;
   logic [WIDTH-1:0]     skid_res_q;
   logic [ALU_SEL_W-1:0] skid_sel_q;
   logic [NUM_FLAGS-1:0] skid_flags_q;

   logic                 sticky_q;
   logic                 accept;
   logic                 xfer;

   alu_flag_gen #(
      .WIDTH      (WIDTH),
      .ARITH_MASK (ARITH_MASK)
   ) u_flag_gen (
      .res   (in_res),
      .sel   (in_sel),
      .cout  (in_cout),
      .ovf   (in_ovf),
      .flags (in_flags)
   );

   // Handshake qualifiers; in_ready comes straight from the skid flop
   always_comb begin
      accept = in_valid & ~skid_valid_q;
      xfer   = out_valid_q & out_ready;
   end

   // Skid buffer state: the output register refills from the skid first so
   // order is kept; the skid only loads when the output is held this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_res_q    <= '0;
         out_sel_q    <= '0;
         out_flags_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_res_q   <= '0;
         skid_sel_q   <= '0;
         skid_flags_q <= '0;
         sticky_q     <= 1'b0;
      end else if (flush) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         sticky_q     <= 1'b0;
      end else begin
         if (accept && in_flags[FLAG_V]) begin
            sticky_q <= 1'b1;
         end
         if (!out_valid_q || xfer) begin
            if (skid_valid_q) begin
               out_valid_q  <= 1'b1;
               out_res_q    <= skid_res_q;
               out_sel_q    <= skid_sel_q;
               out_flags_q  <= skid_flags_q;
               skid_valid_q <= 1'b0;
            end else if (accept) begin
               out_valid_q <= 1'b1;
               out_res_q   <= in_res;
               out_sel_q   <= in_sel;
               out_flags_q <= in_flags;
            end else begin
               out_valid_q <= 1'b0;
            end
         end else if (accept) begin
            skid_valid_q <= 1'b1;
            skid_res_q   <= in_res;
            skid_sel_q   <= in_sel;
            skid_flags_q <= in_flags;
         end
      end
   end

   // Drive ports from registered state only
   always_comb begin
      in_ready  = ~skid_valid_q;
      out_valid = out_valid_q;
      out_res   = out_res_q;
      out_sel   = out_sel_q;
      out_flags = out_flags_q;
      sticky_v  = sticky_q;
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: reference model is an ordered queue of
// accepted results (occupancy limited to two) with flags derived from the
// arithmetic-mask rule, plus a sticky overflow bit.
module tb_alu_result_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_res;
   logic [3:0] in_sel;
   logic       in_cout;
   logic       in_ovf;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_res;
   logic [3:0] out_sel;
   logic [3:0] out_flags;
   logic       sticky_v;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [7:0] res;
      logic [3:0] sel;
      logic [3:0] flags;
   } item_t;

   item_t q[$];
   logic  sticky_m = 1'b0;

   always #5 clk = ~clk;

   alu_result_stage #(
      .WIDTH      (8),
      .ARITH_MASK (16'h000F)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_res    (in_res),
      .in_sel    (in_sel),
      .in_cout   (in_cout),
      .in_ovf    (in_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_sel   (out_sel),
      .out_flags (out_flags),
      .sticky_v  (sticky_v)
   );

   function automatic logic [3:0] ref_flags(input logic [7:0] r, input logic [3:0] s,
                                            input logic c, input logic o);
      logic [15:0] mask;
      logic        arith;
      mask  = 16'h000F;
      arith = mask[s];
      return {r == 8'h00, r[7], arith & c, arith & o};
   endfunction

   // Drive one cycle of stimulus, advance the model, land at posedge+1
   task automatic cycle(input logic iv, input logic [7:0] r, input logic [3:0] s,
                        input logic c, input logic o, input logic ordy, input logic fl);
      item_t it;
      logic  acc;
      in_valid  = iv;
      in_res    = r;
      in_sel    = s;
      in_cout   = c;
      in_ovf    = o;
      out_ready = ordy;
      flush     = fl;
      if (fl) begin
         q.delete();
         sticky_m = 1'b0;
      end else begin
         acc = iv && (q.size() < 2);
         if (ordy && q.size() > 0) void'(q.pop_front());
         if (acc) begin
            it.res   = r;
            it.sel   = s;
            it.flags = ref_flags(r, s, c, o);
            q.push_back(it);
            if (it.flags[0]) sticky_m = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic test_reset;
      n_cmp++;
      if ({out_valid, in_ready, sticky_v, out_res, out_sel, out_flags} !== {1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 4'h0}) begin
         n_err++;
         $display("FAIL reset: got v=%b rdy=%b stk=%b res=%h sel=%h fl=%b, expected 0 1 0 00 0 0000",
                  out_valid, in_ready, sticky_v, out_res, out_sel, out_flags);
      end
   endtask

   task automatic test_streaming;
      logic [3:0] s;
      logic       c, o;
      logic [3:0] ef;
      for (int unsigned i = 0; i < 256; i++) begin
         s = 4'($urandom_range(15, 0));
         c = 1'($urandom_range(1, 0));
         o = 1'($urandom_range(1, 0));
         ef = ref_flags(8'(i), s, c, o);
         cycle(1'b1, 8'(i), s, c, o, 1'b1, 1'b0);
         n_cmp++;
         if ({out_valid, in_ready, out_res, out_sel, out_flags} !== {1'b1, 1'b1, 8'(i), s, ef}) begin
            n_err++;
            $display("FAIL stream[%0d]: got v=%b rdy=%b res=%h sel=%h fl=%b, expected 1 1 %h %h %b",
                     i, out_valid, in_ready, out_res, out_sel, out_flags, 8'(i), s, ef);
         end
      end
      cycle(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stream_drain: out_valid got %b expected 0", out_valid);
      end
   endtask

   task automatic test_backpressure;
      cycle(1'b1, 8'h11, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({out_valid, in_ready, out_res} !== {1'b1, 1'b1, 8'h11}) begin
         n_err++;
         $display("FAIL bp_first: got v=%b rdy=%b res=%h expected 1 1 11", out_valid, in_ready, out_res);
      end
      cycle(1'b1, 8'h22, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({out_valid, in_ready, out_res} !== {1'b1, 1'b0, 8'h11}) begin
         n_err++;
         $display("FAIL bp_full: got v=%b rdy=%b res=%h expected 1 0 11", out_valid, in_ready, out_res);
      end
      // offered while not ready: must be ignored
      cycle(1'b1, 8'h33, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({out_valid, in_ready, out_res} !== {1'b1, 1'b0, 8'h11}) begin
         n_err++;
         $display("FAIL bp_hold: got v=%b rdy=%b res=%h expected 1 0 11", out_valid, in_ready, out_res);
      end
      cycle(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if ({out_valid, in_ready, out_res} !== {1'b1, 1'b1, 8'h22}) begin
         n_err++;
         $display("FAIL bp_second: got v=%b rdy=%b res=%h expected 1 1 22", out_valid, in_ready, out_res);
      end
      cycle(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL bp_empty: got v=%b rdy=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_flags;
      cycle(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (sticky_v !== 1'b0) begin
         n_err++;
         $display("FAIL flags_pre: sticky_v got %b expected 0", sticky_v);
      end
      cycle(1'b1, 8'h80, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if ({out_valid, out_flags, sticky_v} !== {1'b1, 4'b0111, 1'b1}) begin
         n_err++;
         $display("FAIL flags_arith: got v=%b fl=%b stk=%b expected 1 0111 1", out_valid, out_flags, sticky_v);
      end
      cycle(1'b1, 8'h00, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if ({out_valid, out_flags, sticky_v} !== {1'b1, 4'b1000, 1'b1}) begin
         n_err++;
         $display("FAIL flags_logic: got v=%b fl=%b stk=%b expected 1 1000 1", out_valid, out_flags, sticky_v);
      end
      cycle(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_flush;
      cycle(1'b1, 8'hA1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 8'hA2, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({out_valid, in_ready, sticky_v} !== {1'b1, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL flush_fill: got v=%b rdy=%b stk=%b expected 1 0 1", out_valid, in_ready, sticky_v);
      end
      cycle(1'b1, 8'hEE, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if ({out_valid, in_ready, sticky_v} !== {1'b0, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL flush_clear: got v=%b rdy=%b stk=%b expected 0 1 0", out_valid, in_ready, sticky_v);
      end
      for (int unsigned i = 0; i < 3; i++) begin
         cycle(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
         n_cmp++;
         if ({out_valid, sticky_v} !== {1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL flush_after[%0d]: got v=%b res=%h stk=%b expected v=0 stk=0", i, out_valid, out_res, sticky_v);
         end
      end
   endtask

   task automatic test_async_reset;
      cycle(1'b1, 8'h3C, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 8'h3D, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({out_valid, out_res} !== {1'b1, 8'h3C}) begin
         n_err++;
         $display("FAIL areset_pre: got v=%b res=%h expected 1 3c", out_valid, out_res);
      end
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      sticky_m = 1'b0;
      n_cmp++;
      if ({out_valid, in_ready, sticky_v, out_res} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL areset_now: got v=%b rdy=%b stk=%b res=%h expected 0 1 0 00",
                  out_valid, in_ready, sticky_v, out_res);
      end
      #2 rst_n = 1'b1;
      cycle(1'b1, 8'h5A, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if ({out_valid, out_res, out_sel} !== {1'b1, 8'h5A, 4'h9}) begin
         n_err++;
         $display("FAIL areset_post: got v=%b res=%h sel=%h expected 1 5a 9", out_valid, out_res, out_sel);
      end
      cycle(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_random;
      int unsigned n_out;
      logic        st_ok;
      n_out = 0;
      for (int unsigned i = 0; i < 10000; i++) begin
         if (out_valid && out_ready) n_out++;
         cycle(1'($urandom_range(1, 0)), 8'($urandom), 4'($urandom),
               1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
               1'($urandom_range(1, 0)), 1'b0);
         st_ok = 1'b1;
         n_cmp++;
         if ({out_valid, in_ready, sticky_v} !== {q.size() > 0, q.size() < 2, sticky_m}) begin
            n_err++;
            st_ok = 1'b0;
            $display("FAIL rand_state[%0d]: got v=%b rdy=%b stk=%b expected %b %b %b",
                     i, out_valid, in_ready, sticky_v, q.size() > 0, q.size() < 2, sticky_m);
         end
         if (st_ok && q.size() > 0) begin
            n_cmp++;
            if ({out_res, out_sel, out_flags} !== {q[0].res, q[0].sel, q[0].flags}) begin
               n_err++;
               $display("FAIL rand_data[%0d]: got res=%h sel=%h fl=%b expected %h %h %b",
                        i, out_res, out_sel, out_flags, q[0].res, q[0].sel, q[0].flags);
            end
         end
      end
      n_cmp++;
      if (n_out < 1000) begin
         n_err++;
         $display("FAIL rand_throughput: transfers got %0d expected at least 1000", n_out);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_res    = '0;
      in_sel    = '0;
      in_cout   = 1'b0;
      in_ovf    = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset;
      rst_n = 1'b1;
      test_streaming;
      test_backpressure;
      test_flags;
      test_flush;
      test_async_reset;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-low reset.
REQ-002 Parameter: WIDTH, default 8, result data width in bits.
REQ-003 Parameter: ARITH_MASK, default 16'h000F; bit k set means select code k is an arithmetic operation.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: flush  input  1  synchronous clear of all buffered results.
REQ-007 Port: in_valid  input  1  upstream result-mux output valid.
REQ-008 Port: in_ready  output  1  stage can accept a result; registered.
REQ-009 Port: in_res  input  WIDTH  result from the 16:1 result mux.
REQ-010 Port: in_sel  input  4  select code that produced in_res.
REQ-011 Port: in_cout  input  1  adder carry-out for this result.
REQ-012 Port: in_ovf  input  1  adder signed overflow for this result.
REQ-013 Port: out_valid  output  1  out_res, out_sel and out_flags are valid.
REQ-014 Port: out_ready  input  1  downstream accepts the result.
REQ-015 Port: out_res  output  WIDTH  registered result.
REQ-016 Port: out_sel  output  4  registered select code.
REQ-017 Port: out_flags  output  4  {Z,N,C,V}; bit3 is Z.
REQ-018 Port: sticky_v  output  1  set by any accepted result with V=1; cleared only by flush or reset.

Function
REQ-019 The stage SHALL be a 2-entry skid buffer (output register plus skid register), 1-cycle latency, sustaining one transfer per cycle.
REQ-020 Input handshake: input accepted when in_valid && in_ready; output handshake: transfer when out_valid && out_ready.
REQ-021 in_ready SHALL equal NOT skid_valid, taken from a register, never combinationally from out_ready.
REQ-022 On accept: if the output register is empty or transfers this cycle and the skid is empty, data SHALL load the output register; otherwise it SHALL load the skid register.
REQ-023 When the output transfers and the skid is full, skid contents SHALL move to the output register the same cycle, and the skid SHALL clear unless an accept refills it.
REQ-024 out_res, out_sel and out_flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Flags SHALL be computed on accept: Z = (in_res == 0); N = in_res[WIDTH-1]; C = in_cout and V = in_ovf when ARITH_MASK[in_sel]=1, else C=V=0.
REQ-026 Order SHALL be preserved; no result is dropped or duplicated except by flush.
REQ-027 Flush SHALL take priority: the next cycle has out_valid=0, skid empty, in_ready=1, sticky_v=0; an input presented in the flush cycle is discarded.
REQ-028 in_valid with in_ready=0 SHALL NOT change state; upstream holds its data.

Reset
REQ-029 While rst_n=0: out_valid=0, out_res=0, out_sel=0, out_flags=0, sticky_v=0, skid empty, in_ready=1.
REQ-030 Reset asserted mid-transfer SHALL discard both entries immediately and asynchronously.
REQ-031 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package alu_pkg SHALL hold ALU_SEL_W=4, flag bit indices (FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0) and the default ARITH_MASK.
REQ-033 Flag generation SHALL be one combinational sub-module, alu_flag_gen, parameterised by WIDTH and ARITH_MASK.

Verification
REQ-034 Streaming: WIDTH=8, out_ready=1, in_res 0x00 to 0xFF back-to-back -> one output per cycle, 1-cycle latency, in_ready stays 1.
REQ-035 Backpressure: accept 0x11 then 0x22 with out_ready=0 -> in_ready=0, out_res holds 0x11; on out_ready=1, 0x11 then 0x22 are output in order, and in_ready returns to 1.
REQ-036 Flags: sel=0, res=0x80, cout=1, ovf=1 -> flags=0111 and sticky_v=1; sel=5, res=0x00, cout=1, ovf=1 -> flags=1000.
REQ-037 Flush with both entries full and in_valid=1 -> next cycle: out_valid=0, in_ready=1, sticky_v=0; the flush-cycle input is never output.
REQ-038 Asynchronous reset pulse between clock edges with out_valid=1 -> out_valid=0 immediately; the next accept works after rst_n is released.
REQ-039 Random in_valid/out_ready at 50% each for 10k cycles -> scoreboard matches in order with no loss or duplication.
